// File: rtl/tc_line_fill.sv
// Texture-cache line refill: one miss at a time, burst read, 1-cycle registered RAM writes, tag commit.
// Build option TC_FILL_CRITICAL_FIRST_EN: burst starts at the critical word and wraps.
module tc_line_fill #(
  parameter int LINE_WORDS = 16,
  parameter int RAM_WORDS  = 512,
  parameter int ADDR_W     = 32
) (
  input  logic                                         core_clock_i,
  input  logic                                         core_reset_i,
  input  logic                                         miss_valid_i,
  output logic                                         miss_ready_o,
  input  logic [ADDR_W-1:0]                            miss_addr_i,
  input  logic [$clog2(RAM_WORDS/LINE_WORDS)-1:0]      miss_line_i,
  output logic                                         mem_req_o,
  output logic [ADDR_W-1:0]                            mem_addr_o,
  input  logic                                         mem_ack_i,
  input  logic                                         mem_rvalid_i,
  input  logic [31:0]                                  mem_rdata_i,
  output logic [3:0]                                   ram_wr_en_o,
  output logic [$clog2(RAM_WORDS)-1:0]                 ram_wr_addr_o,
  output logic [31:0]                                  ram_wr_data_o,
  output logic                                         tag_inv_o,
  output logic                                         tag_wr_o,
  output logic [$clog2(RAM_WORDS/LINE_WORDS)-1:0]      tag_line_o,
  output logic [ADDR_W-$clog2(RAM_WORDS)-3:0]          tag_value_o,
  output logic                                         crit_valid_o,
  output logic [31:0]                                  crit_data_o,
  output logic                                         fill_busy_o
);
  localparam int WW  = $clog2(LINE_WORDS);
  localparam int LW  = $clog2(RAM_WORDS/LINE_WORDS);
  localparam int RW  = $clog2(RAM_WORDS);
  localparam int TW  = ADDR_W - RW - 2;
  localparam int OFF = WW + 2;

  typedef enum logic [1:0] {IDLE, REQ, FILL, COMMIT} state_t;
  state_t state_q, state_d;

  logic [LW-1:0]     line_q;
  logic [TW-1:0]     tag_q;
  logic [WW-1:0]     cw_q, sw_q, beat_q, word;
  logic [ADDR_W-1:0] addr_q, addr_in;
  logic [WW-1:0]     cw_in, sw_in;
  logic              tag_inv_q, wr_en_q, crit_q;
  logic [RW-1:0]     wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              accept, beat_fire, last_beat;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^miss_addr_i[1:0];
  assign cw_in = miss_addr_i[OFF-1:2];

`ifdef TC_FILL_CRITICAL_FIRST_EN
  assign addr_in = {miss_addr_i[ADDR_W-1:2], 2'b00};
  assign sw_in   = cw_in;
`else
  assign addr_in = {miss_addr_i[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign sw_in   = '0;
`endif

  assign accept    = (state_q == IDLE) && miss_valid_i;
  assign beat_fire = (state_q == FILL) && mem_rvalid_i;
  assign last_beat = beat_q == WW'(LINE_WORDS - 1);
  // Beat counter is line-sized, so the wrap to word 0 is free.
  assign word      = sw_q + beat_q;

  always_comb begin
    state_d      = state_q;
    miss_ready_o = 1'b0;
    mem_req_o    = 1'b0;
    tag_wr_o     = 1'b0;
    fill_busy_o  = 1'b1;
    case (state_q)
      IDLE: begin
        miss_ready_o = !core_reset_i;
        fill_busy_o  = 1'b0;
        if (miss_valid_i) state_d = REQ;
      end
      REQ: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) state_d = FILL;
      end
      FILL:    if (beat_fire && last_beat) state_d = COMMIT;
      COMMIT: begin
        tag_wr_o = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge core_clock_i) begin
    if (core_reset_i) begin
      state_q   <= IDLE;
      line_q    <= '0;
      tag_q     <= '0;
      cw_q      <= '0;
      sw_q      <= '0;
      beat_q    <= '0;
      addr_q    <= '0;
      tag_inv_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      crit_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tag_inv_q <= accept;
      if (accept) begin
        line_q <= miss_line_i;
        tag_q  <= miss_addr_i[ADDR_W-1:RW+2];
        cw_q   <= cw_in;
        sw_q   <= sw_in;
        addr_q <= addr_in;
      end
      if (state_q == REQ && mem_ack_i) beat_q <= '0;
      else if (beat_fire)              beat_q <= beat_q + WW'(1);
      // Write stage: RAM write and critical-word forward share one register.
      wr_en_q <= beat_fire;
      crit_q  <= beat_fire && (word == cw_q);
      if (beat_fire) begin
        wr_addr_q <= {line_q, word};
        wr_data_q <= mem_rdata_i;
      end
    end
  end

  assign mem_addr_o    = addr_q;
  assign ram_wr_en_o   = {4{wr_en_q}};
  assign ram_wr_addr_o = wr_addr_q;
  assign ram_wr_data_o = wr_data_q;
  assign tag_inv_o     = tag_inv_q;
  assign tag_line_o    = line_q;
  assign tag_value_o   = tag_q;
  assign crit_valid_o  = crit_q;
  assign crit_data_o   = wr_data_q;
endmodule
